msk_hpc2o_sched: RTL and testbench

// Issue scheduler for one fMSKand_hpc2o masked-AND gadget. Accepts masked operand pairs and a

---
 rtl/msk_pkg.sv | 18 +
 rtl/msk_share_fifo.sv | 60 ++++++
 rtl/msk_hpc2o_sched.sv | 99 +++++++++
 tb/tb_msk_hpc2o_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/msk_pkg.sv
// Shared definitions for the masked-AND (fMSKand_hpc2o) datapath blocks.
//   hpc2rnd(d)         : fresh random bits one gadget invocation consumes, d*(d-1)/2
//   SHIDX_BITS_DEFAULT : default width of the share-index control word
//   LAT_*              : gadget input/output latencies relative to the inb issue cycle
package msk_pkg;

    localparam int unsigned SHIDX_BITS_DEFAULT = 3;

    localparam int unsigned LAT_B   = 0;
    localparam int unsigned LAT_A   = 1;
    localparam int unsigned LAT_S   = 2;
    localparam int unsigned LAT_OUT = 2;

    function automatic int unsigned hpc2rnd(input int unsigned d);
        return d * (d - 1) / 2;
    endfunction

endpackage

// File: rtl/msk_share_fifo.sv
// First-word-fall-through buffer for output sharings.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write request and data (ignored when full without a pop)
//   pop                 : consume head entry (ignored when empty)
//   out_valid, out_data : head entry; out_data is driven 0 when empty
//   count               : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module msk_share_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage holds share data only; no reset so no reset-dependent share recombination.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= push_data;
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rptr_q];
    assign count     = count_q;

endmodule

// File: rtl/msk_hpc2o_sched.sv
// Issue scheduler for one fMSKand_hpc2o gadget.
//   in_valid/in_ready, in_a, in_b, in_s : operand request (two sharings + share-index word)
//   rnd_valid/rnd_ready                 : PRNG handshake, one word per issued op
//   g_inb (@0), g_ina/g_inb_prev (@1), g_s (@2) : latency-staggered gadget inputs
//   g_out                               : gadget result, captured two cycles after issue
//   out_valid/out_ready, out_data       : buffered result sharings
//   busy                                : any op in the pipeline or the buffer
// Credits reserve a buffer slot for every op in flight, because the gadget cannot stall.
module msk_hpc2o_sched
    import msk_pkg::*;
#(
    parameter int unsigned d          = 2,
    parameter int unsigned SHIDX_BITS = SHIDX_BITS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [d-1:0]          in_a,
    input  logic [d-1:0]          in_b,
    input  logic [SHIDX_BITS-1:0] in_s,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic [d-1:0]          g_inb,
    output logic [d-1:0]          g_ina,
    output logic [d-1:0]          g_inb_prev,
    output logic [SHIDX_BITS-1:0] g_s,
    input  logic [d-1:0]          g_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [d-1:0]          out_data,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                  run_q;
    logic                  st1_v_q, st2_v_q;
    logic [d-1:0]          st1_a_q, st1_b_q;
    logic [SHIDX_BITS-1:0] st1_s_q, st2_s_q;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           used;
    logic                  credit_ok, fire;

    // Slots already spoken for: buffered results plus ops still in the gadget.
    always_comb begin
        used = {1'b0, fifo_count} + (CW+1)'(st1_v_q) + (CW+1)'(st2_v_q);
    end

    // run_q keeps the request side closed while reset is asserted.
    assign credit_ok = run_q && (used < (CW+1)'(FIFO_DEPTH));
    assign in_ready  = rnd_valid & credit_ok;
    assign rnd_ready = in_valid & credit_ok;
    assign fire      = in_valid & in_ready;

    // Invalid stages present all-zero to the gadget, never stale shares.
    assign g_inb      = fire    ? in_b    : '0;
    assign g_ina      = st1_v_q ? st1_a_q : '0;
    assign g_inb_prev = st1_v_q ? st1_b_q : '0;
    assign g_s        = st2_v_q ? st2_s_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            st1_v_q <= 1'b0;
            st2_v_q <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            st1_v_q <= fire;
            st2_v_q <= st1_v_q;
        end
    end

    // Share-carrying registers: no reset; cleared to zero whenever the stage is empty.
    always_ff @(posedge clk) begin
        st1_a_q <= fire ? in_a : '0;
        st1_b_q <= fire ? in_b : '0;
        st1_s_q <= fire ? in_s : '0;
        st2_s_q <= st1_v_q ? st1_s_q : '0;
    end

    msk_share_fifo #(
        .W     (d),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (st2_v_q),
        .push_data (g_out),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (fifo_count)
    );

    assign busy = st1_v_q | st2_v_q | (fifo_count != '0);

endmodule

// File: tb/tb_msk_hpc2o_sched.sv
module tb_msk_hpc2o_sched;

    localparam int unsigned D  = 2;
    localparam int unsigned SB = 3;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, rnd_valid, rnd_ready;
    logic [D-1:0]  in_a, in_b, g_inb, g_ina, g_inb_prev, g_out, out_data;
    logic [SB-1:0] in_s, g_s;
    logic          out_valid, out_ready, busy;

    always #5 clk = ~clk;

    msk_hpc2o_sched #(
        .d          (D),
        .SHIDX_BITS (SB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_s       (in_s),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .g_inb      (g_inb),
        .g_ina      (g_ina),
        .g_inb_prev (g_inb_prev),
        .g_s        (g_s),
        .g_out      (g_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    // Gadget stand-in: out = ina(@1) ^ inb(@0) when s != 0, aligned at latency 2.
    logic [D-1:0] ina_r = '0, inb_r1 = '0, inb_r2 = '0;
    always @(posedge clk) begin
        ina_r  <= g_ina;
        inb_r1 <= g_inb;
        inb_r2 <= inb_r1;
    end
    assign g_out = (g_s != '0) ? (ina_r ^ inb_r2) : '0;

    int checks = 0;
    int errors = 0;
    logic [D-1:0] exp_q [$];

    function automatic logic [D-1:0] model(input logic [D-1:0] a, input logic [D-1:0] b,
                                           input logic [SB-1:0] s);
        return (s == '0) ? '0 : (a ^ b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accepted request, pop/compare on accepted output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_s));
            if (exp_q.size() == 0) chk("out_valid_spurious", {31'b0, out_valid}, 0);
            else if (out_valid && out_ready) chk("out_data", {30'b0, out_data}, exp_q.pop_front());
            if (!out_valid) chk("out_data_idle_zero", {30'b0, out_data}, 0);
        end
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input logic [D-1:0] a, input logic [D-1:0] b,
                             input logic [SB-1:0] s);
        logic [D-1:0] e;
        e = model(a, b, s);
        drive_pt();
        in_valid = 1'b1; in_a = a; in_b = b; in_s = s;
        @(negedge clk);
        chk("op_in_ready_T", {31'b0, in_ready}, 1);
        chk("op_g_inb_T", {30'b0, g_inb}, {30'b0, b});
        drive_pt();
        in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0;
        @(negedge clk);
        chk("op_g_ina_T1", {30'b0, g_ina}, {30'b0, a});
        chk("op_g_inb_prev_T1", {30'b0, g_inb_prev}, {30'b0, b});
        chk("op_g_inb_T1_zero", {30'b0, g_inb}, 0);
        chk("op_g_s_T1_zero", {29'b0, g_s}, 0);
        @(negedge clk);
        chk("op_g_s_T2", {29'b0, g_s}, {29'b0, s});
        chk("op_g_ina_T2_zero", {30'b0, g_ina}, 0);
        chk("op_out_valid_T2", {31'b0, out_valid}, 0);
        @(negedge clk);
        chk("op_out_valid_T3", {31'b0, out_valid}, 1);
        chk("op_out_data_T3", {30'b0, out_data}, {30'b0, e});
        @(negedge clk);
        chk("op_out_valid_T4", {31'b0, out_valid}, 0);
        chk("op_busy_T4", {31'b0, busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        in_valid = 1'b1; in_a = 2'b01; in_b = 2'b11; in_s = 3'b111;
        rnd_valid = 1'b1; out_ready = 1'b1;

        // Reset state, with a request pending to make the gating meaningful.
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_rnd_ready", {31'b0, rnd_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_g_inb", {30'b0, g_inb}, 0);
        chk("rst_out_data", {30'b0, out_data}, 0);
        in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0;
        #6 rst_n = 1'b1;
        drive_pt();
        drive_pt();

        // Scenario 1: single op.
        single_op(2'b01, 2'b11, 3'b111);

        // Scenario 2: 8 back-to-back ops, outputs on 8 consecutive cycles.
        for (int j = 0; j < 12; j++) begin
            drive_pt();
            if (j < 8) begin
                in_valid = 1'b1; in_a = j[1:0]; in_b = ~j[1:0]; in_s = 3'(j + 1);
            end else begin
                in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0;
            end
            @(negedge clk);
            if (j < 8) chk("b2b_in_ready", {31'b0, in_ready}, 1);
            chk("b2b_out_valid", {31'b0, out_valid}, (j >= 3 && j < 11) ? 1 : 0);
        end

        // Scenario 3: stalled consumer, credits stop issue at FIFO_DEPTH.
        out_ready = 1'b0;
        fires = 0;
        for (int j = 0; j < 10; j++) begin
            drive_pt();
            in_valid = 1'b1; in_a = 2'(j + 1); in_b = 2'(j); in_s = 3'b101;
            @(negedge clk);
            if (in_valid && in_ready) fires++;
        end
        chk("stall_fire_count", fires, FD);
        chk("stall_in_ready", {31'b0, in_ready}, 0);
        chk("stall_out_valid", {31'b0, out_valid}, 1);
        chk("stall_busy", {31'b0, busy}, 1);
        for (int j = 0; j < 5; j++) begin
            drive_pt();
            in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            chk("drain_out_valid", {31'b0, out_valid}, (j < 4) ? 1 : 0);
        end

        // Scenario 4: no PRNG word, no issue and gadget inputs stay zero.
        drive_pt();
        in_valid = 1'b1; in_a = 2'b11; in_b = 2'b10; in_s = 3'b011; rnd_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("nornd_in_ready", {31'b0, in_ready}, 0);
            chk("nornd_rnd_ready", {31'b0, rnd_ready}, 1);
            chk("nornd_g_inb", {30'b0, g_inb}, 0);
            chk("nornd_g_ina", {30'b0, g_ina}, 0);
            chk("nornd_g_inb_prev", {30'b0, g_inb_prev}, 0);
            chk("nornd_g_s", {29'b0, g_s}, 0);
            if (j < 2) drive_pt();
        end
        drive_pt();
        in_valid = 1'b0; rnd_valid = 1'b1;
        for (int j = 0; j < 3; j++) drive_pt();
        @(negedge clk);
        chk("nornd_busy_idle", {31'b0, busy}, 0);

        // Scenario 5: reset at T+1 drops the op immediately.
        drive_pt();
        in_valid = 1'b1; in_a = 2'b10; in_b = 2'b01; in_s = 3'b011;
        @(negedge clk);
        chk("rstop_in_ready", {31'b0, in_ready}, 1);
        drive_pt();
        in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rstop_busy", {31'b0, busy}, 0);
        chk("rstop_g_ina", {30'b0, g_ina}, 0);
        chk("rstop_g_inb_prev", {30'b0, g_inb_prev}, 0);
        chk("rstop_g_inb", {30'b0, g_inb}, 0);
        chk("rstop_g_s", {29'b0, g_s}, 0);
        chk("rstop_out_valid", {31'b0, out_valid}, 0);
        drive_pt();
        drive_pt();
        #2 rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("rstop_no_out", {31'b0, out_valid}, 0);
        end
        single_op(2'b01, 2'b11, 3'b111);

        // Scenario 6: s = 0 still produces a (zero) result.
        single_op(2'b10, 2'b11, 3'b000);

        drive_pt();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
